// File: rtl/execute_unit.sv
// Single-cycle RV32 integer execute stage: operand select, ALU, registered trace copy.
// Optional branch compare outputs enabled by macro EXU_BRANCH_CMP_EN.
module execute_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      funcEU,
  input  logic [1:0]      amux1,
  input  logic [1:0]      amux2,
  output logic [XLEN-1:0] aluout,
  output logic [XLEN-1:0] aluout_q,
  output logic            zero,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_ltu
);

  localparam logic [2:0] FN_ADD  = 3'd0;
  localparam logic [2:0] FN_SUB  = 3'd1;
  localparam logic [2:0] FN_AND  = 3'd2;
  localparam logic [2:0] FN_OR   = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;
  localparam logic [2:0] FN_SLT  = 3'd5;
  localparam logic [2:0] FN_SLTU = 3'd6;
  localparam logic [2:0] FN_JALR = 3'd7;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] sum;

  // Operand A: unmatched or unknown keys fall to zero
  always_comb begin
    op_a = '0;
    case (amux1)
      2'd0:    op_a = src1;
      2'd1:    op_a = pc;
      default: op_a = '0;
    endcase
  end

  // Operand B: the constant 4 serves link-address (pc+4) generation
  always_comb begin
    op_b = '0;
    case (amux2)
      2'd0:    op_b = src2;
      2'd1:    op_b = imm;
      2'd2:    op_b = XLEN'(4);
      default: op_b = '0;
    endcase
  end

  assign sum = op_a + op_b;

  always_comb begin
    aluout = '0;
    case (funcEU)
      FN_ADD:  aluout = sum;
      FN_SUB:  aluout = op_a - op_b;
      FN_AND:  aluout = op_a & op_b;
      FN_OR:   aluout = op_a | op_b;
      FN_XOR:  aluout = op_a ^ op_b;
      FN_SLT:  aluout = XLEN'($signed(op_a) < $signed(op_b));
      FN_SLTU: aluout = XLEN'(op_a < op_b);
      FN_JALR: aluout = sum & ~XLEN'(1);
      default: aluout = '0;
    endcase
  end

  assign zero = (aluout == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      aluout_q <= '0;
    end else begin
      aluout_q <= aluout;
    end
  end

`ifdef EXU_BRANCH_CMP_EN
  // Compares use raw register values, independent of the ALU operand muxes
  assign br_eq  = (src1 == src2);
  assign br_lt  = ($signed(src1) < $signed(src2));
  assign br_ltu = (src1 < src2);
`else
  assign br_eq  = 1'b0;
  assign br_lt  = 1'b0;
  assign br_ltu = 1'b0;
`endif

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit; expected aluout_q values are queued and checked one edge later.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src1, src2, imm, pc;
  logic [2:0]  funcEU;
  logic [1:0]  amux1, amux2;
  logic [31:0] aluout, aluout_q;
  logic        zero, br_eq, br_lt, br_ltu;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_exp [$];

  execute_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .imm(imm), .pc(pc),
    .funcEU(funcEU), .amux1(amux1), .amux2(amux2),
    .aluout(aluout), .aluout_q(aluout_q), .zero(zero),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu)
  );

  always #5 clk = ~clk;

  task automatic check_q(input string tag);
    logic [31:0] e;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      assert (aluout_q === e) else begin
        errors++;
        $error("FAIL %s aluout_q: got %h expected %h", tag, aluout_q, e);
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] a1, input logic [1:0] a2,
                      input logic [2:0] f, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] im, input logic [31:0] p, input logic [31:0] e,
                      input string tag);
    logic eeq, elt, eltu;
    @(negedge clk);
    check_q(tag);
    rst = r; amux1 = a1; amux2 = a2; funcEU = f;
    src1 = s1; src2 = s2; imm = im; pc = p;
`ifdef EXU_BRANCH_CMP_EN
    eeq  = (s1 == s2);
    elt  = ($signed(s1) < $signed(s2));
    eltu = (s1 < s2);
`else
    eeq = 1'b0; elt = 1'b0; eltu = 1'b0;
`endif
    #1;
    checks++;
    assert (aluout === e) else begin
      errors++;
      $error("FAIL %s aluout: got %h expected %h", tag, aluout, e);
    end
    checks++;
    assert (zero === (e == 32'd0)) else begin
      errors++;
      $error("FAIL %s zero: got %b expected %b", tag, zero, (e == 32'd0));
    end
    checks++;
    assert ({br_eq, br_lt, br_ltu} === {eeq, elt, eltu}) else begin
      errors++;
      $error("FAIL %s br eq/lt/ltu: got %b%b%b expected %b%b%b", tag,
             br_eq, br_lt, br_ltu, eeq, elt, eltu);
    end
    q_exp.push_back(r ? e : 32'd0);
  endtask

  initial begin
    rst = 1'b0; amux1 = 2'd0; amux2 = 2'd0; funcEU = 3'd0;
    src1 = '0; src2 = '0; imm = '0; pc = '0;
    //   rst  a1     a2     f     src1          src2          imm           pc            expected
    step(1'b0, 2'd0, 2'd1, 3'd0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd0,        32'd4,        "add_reset");
    step(1'b1, 2'd2, 2'd1, 3'd0, 32'd0,        32'd0,        32'h12345000, 32'd0,        32'h12345000, "lui");
    step(1'b1, 2'd1, 2'd1, 3'd0, 32'd0,        32'd0,        32'h12345000, 32'h80000000, 32'h92345000, "auipc");
    step(1'b1, 2'd0, 2'd1, 3'd7, 32'h80000003, 32'd0,        32'd2,        32'd0,        32'h80000004, "jalr");
    step(1'b1, 2'd0, 2'd0, 3'd5, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd1,        "slt_neg");
    step(1'b1, 2'd0, 2'd0, 3'd6, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        32'd0,        "sltu_big");
    step(1'b1, 2'd3, 2'd3, 3'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'd0,        "defaults");
    step(1'b1, 2'd0, 2'd0, 3'd1, 32'd3,        32'd3,        32'd0,        32'd0,        32'd0,        "sub_zero");
    step(1'b1, 2'd0, 2'd2, 3'd0, 32'h51,       32'd0,        32'd0,        32'd0,        32'h55,       "add_four");
    step(1'b1, 2'd0, 2'd0, 3'd2, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,        32'hF000,     "and");
    step(1'b1, 2'd0, 2'd0, 3'd3, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,        32'hFFF0,     "or");
    step(1'b1, 2'd0, 2'd0, 3'd4, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,        32'h0FF0,     "xor");
    step(1'b1, 2'd2, 2'd0, 3'd1, 32'd9,        32'd1,        32'd0,        32'd0,        32'hFFFFFFFF, "sub_wrap");
    step(1'b0, 2'd0, 2'd2, 3'd0, 32'd1,        32'd0,        32'd0,        32'd0,        32'd5,        "midrun_reset");
    step(1'b1, 2'd2, 2'd2, 3'd0, 32'd7,        32'd7,        32'd0,        32'd0,        32'd4,        "br_equal");
    step(1'b1, 2'd0, 2'd0, 3'd5, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        "slt_pos");
    step(1'b1, 2'd0, 2'd0, 3'd6, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        32'd1,        "sltu_small");
    step(1'b1, 2'd1, 2'd1, 3'd7, 32'd0,        32'd0,        32'hFFFFFFFF, 32'h00001000, 32'h00000FFE, "jalr_pc");
    @(negedge clk);
    check_q("flush");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
